adc_capture_sequencer: RTL and testbench

//  Sequences one triggered capture from the ADC magnitude stream (|A|+|B| sum, one

---
 rtl/adc_capture_sequencer_if.sv | 24 ++
 rtl/adc_capture_sequencer.sv | 177 +++++++++++++++++
 tb/tb_adc_capture_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_sequencer_if.sv
// Stream interfaces for the capture sequencer: ADC sample input (no backpressure)
// and the AXI-Stream style beat output toward the DMA/FIFO.

interface adc_sample_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;

    modport master (output tdata, output tvalid);
    modport slave  (input  tdata, input  tvalid);
endinterface

interface adc_capture_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/adc_capture_sequencer.sv
// Threshold-triggered burst capture from the ADC magnitude stream into a stream sink,
// with holdoff, optional auto re-arm and a single output register stage.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  ST_IDLE    | waiting for arm; config inputs sampled on arm
//  ST_ARMED   | discarding samples until one is strictly above the level
//  ST_CAPTURE | every valid sample becomes a burst beat until N beats sent
//  ST_HOLDOFF | down-counting the holdoff interval, then ARMED or IDLE

module adc_capture_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int EVT_WIDTH  = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   auto_rearm,
    input  logic [DATA_WIDTH-1:0]  trigger_level,
    input  logic [CNT_WIDTH-1:0]   post_samples,
    input  logic [CNT_WIDTH-1:0]   holdoff_cycles,
    adc_sample_if.slave            s_axis,
    adc_capture_sequencer_if.master m_axis,
    output logic                   busy,
    output logic                   triggered,
    output logic                   overflow,
    output logic [EVT_WIDTH-1:0]   capture_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [EVT_WIDTH-1:0] EVT_ONE  = {{(EVT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            state_q,     state_d;
    logic [DATA_WIDTH-1:0] level_q,     level_d;
    logic [CNT_WIDTH-1:0]  n_beats_q,   n_beats_d;
    logic [CNT_WIDTH-1:0]  hold_len_q,  hold_len_d;
    logic                  auto_q,      auto_d;
    logic [CNT_WIDTH-1:0]  rem_q,       rem_d;
    logic [CNT_WIDTH-1:0]  hold_cnt_q,  hold_cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q,  out_last_d;
    logic                  overflow_q,  overflow_d;
    logic [EVT_WIDTH-1:0]  count_q,     count_d;

    logic                  sample_hit;
    logic                  beat_new;
    logic                  beat_last;
    logic [CNT_WIDTH-1:0]  rem_cur;

    // In ARMED the trigger sample is beat 1, so the remaining count is the full burst length.
    always_comb begin
        rem_cur    = (state_q == ST_ARMED) ? n_beats_q : rem_q;
        sample_hit = s_axis.tvalid &&
                     (((state_q == ST_ARMED) && (s_axis.tdata > level_q)) ||
                      (state_q == ST_CAPTURE));
        beat_new   = sample_hit && !abort;
        beat_last  = (rem_cur == CNT_ONE);
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        n_beats_d   = n_beats_q;
        hold_len_d  = hold_len_q;
        auto_d      = auto_q;
        rem_d       = rem_q;
        hold_cnt_d  = hold_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        overflow_d  = overflow_q;
        count_d     = count_q;

        if (out_valid_q && m_axis.tready) begin
            out_valid_d = 1'b0;
        end

        // A beat arriving while the register is full and not draining is dropped.
        if (beat_new) begin
            if (!out_valid_q || m_axis.tready) begin
                out_valid_d = 1'b1;
                out_data_d  = s_axis.tdata;
                out_last_d  = beat_last;
            end else begin
                overflow_d  = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    level_d    = trigger_level;
                    n_beats_d  = (post_samples == CNT_ZERO) ? CNT_ONE : post_samples;
                    hold_len_d = (holdoff_cycles == CNT_ZERO) ? CNT_ONE : holdoff_cycles;
                    auto_d     = auto_rearm;
                    overflow_d = 1'b0;
                    state_d    = ST_ARMED;
                end
            end
            ST_ARMED, ST_CAPTURE: begin
                if (beat_new) begin
                    if (beat_last) begin
                        count_d    = count_q + EVT_ONE;
                        hold_cnt_d = hold_len_q;
                        state_d    = ST_HOLDOFF;
                    end else begin
                        rem_d      = rem_cur - CNT_ONE;
                        state_d    = ST_CAPTURE;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (hold_cnt_q == CNT_ONE) begin
                    state_d = auto_q ? ST_ARMED : ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            n_beats_q   <= '0;
            hold_len_q  <= '0;
            auto_q      <= 1'b0;
            rem_q       <= '0;
            hold_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            n_beats_q   <= n_beats_d;
            hold_len_q  <= hold_len_d;
            auto_q      <= auto_d;
            rem_q       <= rem_d;
            hold_cnt_q  <= hold_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
        end
    end

    assign m_axis.tdata  = out_data_q;
    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tlast  = out_last_q;

    assign busy          = (state_q != ST_IDLE);
    assign triggered     = (state_q == ST_CAPTURE);
    assign overflow      = overflow_q;
    assign capture_count = count_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer: trigger, burst length, backpressure,
// holdoff/re-arm, abort and async reset, checked with immediate assertions.

module tb_adc_capture_sequencer;

    logic        aclk;
    logic        aresetn;
    logic        arm;
    logic        abort;
    logic        auto_rearm;
    logic [15:0] trigger_level;
    logic [15:0] post_samples;
    logic [15:0] holdoff_cycles;
    logic        busy;
    logic        triggered;
    logic        overflow;
    logic [15:0] capture_count;

    int n_asserts = 0;
    int n_fail    = 0;

    adc_sample_if            #(.DATA_WIDTH(16)) s_if ();
    adc_capture_sequencer_if #(.DATA_WIDTH(16)) m_if ();

    adc_capture_sequencer #(
        .DATA_WIDTH(16),
        .CNT_WIDTH (16),
        .EVT_WIDTH (16)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .arm           (arm),
        .abort         (abort),
        .auto_rearm    (auto_rearm),
        .trigger_level (trigger_level),
        .post_samples  (post_samples),
        .holdoff_cycles(holdoff_cycles),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .busy          (busy),
        .triggered     (triggered),
        .overflow      (overflow),
        .capture_count (capture_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic sample(input logic v, input logic [15:0] d);
        s_if.tvalid = v;
        s_if.tdata  = d;
        cyc();
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    initial begin
        aresetn        = 1'b0;
        arm            = 1'b0;
        abort          = 1'b0;
        auto_rearm     = 1'b0;
        trigger_level  = 16'd0;
        post_samples   = 16'd0;
        holdoff_cycles = 16'd0;
        s_if.tvalid    = 1'b0;
        s_if.tdata     = 16'd0;
        m_if.tready    = 1'b1;
        cyc();
        cyc();
        chk("rst_tvalid",    m_if.tvalid,   0);
        chk("rst_busy",      busy,          0);
        chk("rst_triggered", triggered,     0);
        chk("rst_overflow",  overflow,      0);
        chk("rst_count",     capture_count, 0);
        aresetn = 1'b1;
        cyc();

        // Basic burst of 4; config changes after arm must not matter
        trigger_level = 16'd1000; post_samples = 16'd4; holdoff_cycles = 16'd2; auto_rearm = 1'b0;
        do_arm();
        trigger_level = 16'd0; post_samples = 16'd1;
        chk("t1_busy_armed", busy, 1);
        chk("t1_not_trig",   triggered, 0);
        sample(1'b1, 16'd999);
        chk("t1_below_level", m_if.tvalid, 0);
        sample(1'b1, 16'd1000);
        chk("t1_at_level", m_if.tvalid, 0);
        chk("t1_at_level_state", triggered, 0);
        sample(1'b1, 16'd1001);
        chk("t1_b1_valid", m_if.tvalid, 1);
        chk("t1_b1_data",  m_if.tdata,  1001);
        chk("t1_b1_last",  m_if.tlast,  0);
        chk("t1_trig",     triggered,   1);
        sample(1'b1, 16'd5);
        chk("t1_b2_data",  m_if.tdata, 5);
        sample(1'b1, 16'd6);
        chk("t1_b3_data",  m_if.tdata, 6);
        chk("t1_b3_last",  m_if.tlast, 0);
        sample(1'b1, 16'd7);
        chk("t1_b4_valid", m_if.tvalid, 1);
        chk("t1_b4_data",  m_if.tdata,  7);
        chk("t1_b4_last",  m_if.tlast,  1);
        chk("t1_count",    capture_count, 1);
        chk("t1_holdoff_trig", triggered, 0);
        chk("t1_holdoff_busy", busy, 1);
        sample(1'b1, 16'd8);
        chk("t1_no_extra_beat", m_if.tvalid, 0);
        chk("t1_holdoff_busy2", busy, 1);
        sample(1'b0, 16'd0);
        chk("t1_idle", busy, 0);

        // post_samples=0 behaves as a single-beat burst
        trigger_level = 16'd10; post_samples = 16'd0; holdoff_cycles = 16'd0;
        do_arm();
        sample(1'b1, 16'd11);
        chk("t2_valid", m_if.tvalid, 1);
        chk("t2_data",  m_if.tdata,  11);
        chk("t2_last",  m_if.tlast,  1);
        chk("t2_count", capture_count, 2);
        chk("t2_holdoff_busy", busy, 1);
        chk("t2_holdoff_trig", triggered, 0);
        sample(1'b0, 16'd0);
        chk("t2_drained", m_if.tvalid, 0);
        chk("t2_idle", busy, 0);

        // Backpressure through the whole burst
        trigger_level = 16'd100; post_samples = 16'd4; holdoff_cycles = 16'd1;
        m_if.tready = 1'b0;
        do_arm();
        sample(1'b1, 16'd200);
        chk("t3_b1_data", m_if.tdata, 200);
        chk("t3_no_ovf_yet", overflow, 0);
        sample(1'b1, 16'd201);
        chk("t3_ovf", overflow, 1);
        chk("t3_held_data", m_if.tdata, 200);
        sample(1'b1, 16'd202);
        sample(1'b1, 16'd203);
        chk("t3_held_valid", m_if.tvalid, 1);
        chk("t3_held_data2", m_if.tdata, 200);
        chk("t3_held_last",  m_if.tlast, 0);
        chk("t3_count", capture_count, 3);
        m_if.tready = 1'b1;
        sample(1'b0, 16'd0);
        chk("t3_drained", m_if.tvalid, 0);
        chk("t3_idle", busy, 0);
        chk("t3_ovf_sticky", overflow, 1);
        do_arm();
        chk("t3_arm_clears_ovf", overflow, 0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("t3_abort_armed", busy, 0);

        // Auto re-arm with holdoff of 10: crossings during holdoff ignored
        trigger_level = 16'd50; post_samples = 16'd2; holdoff_cycles = 16'd10; auto_rearm = 1'b1;
        do_arm();
        auto_rearm = 1'b0;
        sample(1'b1, 16'd60);
        chk("t4_b1_data", m_if.tdata, 60);
        sample(1'b1, 16'd1);
        chk("t4_b2_last", m_if.tlast, 1);
        chk("t4_count1", capture_count, 4);
        for (int i = 0; i < 10; i++) begin
            sample(1'b1, 16'd99);
            chk("t4_holdoff_ignored", m_if.tvalid, 0);
        end
        chk("t4_rearmed_busy", busy, 1);
        chk("t4_rearmed_trig", triggered, 0);
        sample(1'b1, 16'd70);
        chk("t4_second_valid", m_if.tvalid, 1);
        chk("t4_second_data",  m_if.tdata, 70);
        chk("t4_second_trig",  triggered, 1);
        sample(1'b1, 16'd3);
        chk("t4_second_last", m_if.tlast, 1);
        chk("t4_count2", capture_count, 5);
        abort = 1'b1;
        sample(1'b0, 16'd0);
        abort = 1'b0;
        chk("t4_abort_holdoff", busy, 0);

        // Abort mid-burst with a pending beat
        trigger_level = 16'd0; post_samples = 16'd8; holdoff_cycles = 16'd3;
        do_arm();
        sample(1'b1, 16'd5);
        chk("t5_b1_data", m_if.tdata, 5);
        sample(1'b1, 16'd6);
        chk("t5_b2_data", m_if.tdata, 6);
        m_if.tready = 1'b0;
        abort = 1'b1;
        sample(1'b1, 16'd7);
        abort = 1'b0;
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_trig", triggered, 0);
        chk("t5_pending_valid", m_if.tvalid, 1);
        chk("t5_pending_data",  m_if.tdata, 6);
        chk("t5_count_same", capture_count, 5);
        sample(1'b1, 16'd8);
        chk("t5_no_new_beat", m_if.tdata, 6);
        chk("t5_no_ovf", overflow, 0);
        m_if.tready = 1'b1;
        sample(1'b0, 16'd0);
        chk("t5_drained", m_if.tvalid, 0);
        arm = 1'b1; abort = 1'b1;
        cyc();
        arm = 1'b0; abort = 1'b0;
        chk("t5_arm_abort", busy, 0);
        sample(1'b1, 16'd9);
        chk("t5_idle_no_beat", m_if.tvalid, 0);
        chk("t5_count_final", capture_count, 5);

        // Async reset mid-burst
        post_samples = 16'd4; holdoff_cycles = 16'd1;
        m_if.tready = 1'b0;
        do_arm();
        sample(1'b1, 16'd9);
        chk("t6_pre_valid", m_if.tvalid, 1);
        s_if.tvalid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_valid", m_if.tvalid, 0);
        chk("t6_rst_busy",  busy, 0);
        chk("t6_rst_trig",  triggered, 0);
        chk("t6_rst_count", capture_count, 0);
        chk("t6_rst_ovf",   overflow, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        m_if.tready = 1'b1;
        cyc();
        do_arm();
        chk("t6_rearm_busy", busy, 1);
        sample(1'b1, 16'd20);
        chk("t6_b1_data", m_if.tdata, 20);
        chk("t6_b1_count", capture_count, 0);
        sample(1'b1, 16'd21);
        sample(1'b1, 16'd22);
        sample(1'b1, 16'd23);
        chk("t6_b4_data", m_if.tdata, 23);
        chk("t6_b4_last", m_if.tlast, 1);
        chk("t6_count", capture_count, 1);
        s_if.tvalid = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
